// File: rtl/watchdog_win_pkg.sv
// Shared constants for the windowed watchdog: register map, CTRL/STATUS bit
// positions and the core state encoding.
package watchdog_win_pkg;

    localparam logic [7:0] ADDR_CTRL       = 8'h08;
    localparam logic [7:0] ADDR_STATUS     = 8'h09;
    localparam logic [7:0] ADDR_TIMER_INIT = 8'h0a;
    localparam logic [7:0] ADDR_WINDOW     = 8'h0b;
    localparam logic [7:0] ADDR_PRESCALE   = 8'h0c;
    localparam logic [7:0] ADDR_CURR_TIMER = 8'h0d;

    localparam int CTRL_START   = 0;
    localparam int CTRL_STOP    = 1;
    localparam int CTRL_KICK    = 2;

    localparam int STAT_RUNNING = 0;
    localparam int STAT_TIMEOUT = 1;
    localparam int STAT_EARLY   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

endpackage

// File: rtl/watchdog_win_if.sv
// Register bus bundle of the watchdog: master drives the request, slave
// answers combinationally with read_data/ready.
interface watchdog_win_if;

    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (output cs, output we, output address, output write_data,
                    input read_data, input ready);
    modport slave  (input cs, input we, input address, input write_data,
                    output read_data, output ready);

endinterface

// File: rtl/watchdog_win_core.sv
// Watchdog engine: FSM, prescaler, down-counter and (with WATCHDOG_WIN_WINDOW_EN)
// the early-kick window compare.
module watchdog_win_core
    import watchdog_win_pkg::*;
#(
    parameter int TIMER_WIDTH    = 28,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_start,
    input  logic                      i_stop,
    input  logic                      i_kick,
    input  logic [TIMER_WIDTH-1:0]    i_timer_init,
`ifdef WATCHDOG_WIN_WINDOW_EN
    input  logic [TIMER_WIDTH-1:0]    i_window,
`endif
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    output logic                      o_running,
    output logic                      o_expired,
    output logic                      o_early,
    output logic [TIMER_WIDTH-1:0]    o_curr_timer
);

    state_t                    r_state;
    state_t                    w_next_state;
    logic [TIMER_WIDTH-1:0]    r_count;
    logic [PRESCALE_WIDTH-1:0] r_presc;
    logic                      r_early;
    logic                      w_tick;
    logic                      w_kick_ok;
    logic                      w_start_ok;

    assign w_tick     = (r_state == ST_RUNNING) && (r_presc == i_prescale);
    assign w_start_ok = i_start && !i_stop;

`ifdef WATCHDOG_WIN_WINDOW_EN
    assign w_kick_ok = (r_count <= i_window);
`else
    assign w_kick_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Priority in RUNNING: STOP, then KICK (valid or early), then the tick.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_next_state = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (i_stop)                         w_next_state = ST_IDLE;
                else if (i_kick)                    w_next_state = w_kick_ok ? ST_RUNNING : ST_EXPIRED;
                else if (w_tick && r_count == '0)   w_next_state = ST_EXPIRED;
            end
            ST_EXPIRED: w_next_state = ST_EXPIRED;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_running = (r_state == ST_RUNNING);
        o_expired = (r_state == ST_EXPIRED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_presc <= '0;
            r_early <= 1'b0;
        end else if (r_state == ST_IDLE && w_start_ok) begin
            r_count <= i_timer_init;
            r_presc <= '0;
        end else if (r_state == ST_RUNNING && !i_stop) begin
            if (i_kick) begin
                if (w_kick_ok) begin
                    r_count <= i_timer_init;
                    r_presc <= '0;
                end else begin
                    r_early <= 1'b1;
                end
            end else if (w_tick) begin
                r_presc <= '0;
                if (r_count != '0) r_count <= r_count - TIMER_WIDTH'(1);
            end else begin
                r_presc <= r_presc + PRESCALE_WIDTH'(1);
            end
        end
    end

    assign o_early      = r_early;
    assign o_curr_timer = r_count;

endmodule

// File: rtl/watchdog_win.sv
// Windowed watchdog top: bus decode, config/pulse registers around the core.
// Optional early-kick window enabled by defining WATCHDOG_WIN_WINDOW_EN.
module watchdog_win
    import watchdog_win_pkg::*;
#(
    parameter int                        TIMER_WIDTH      = 28,
    parameter int                        PRESCALE_WIDTH   = 8,
    parameter logic [TIMER_WIDTH-1:0]    DEFAULT_TIMEOUT  = TIMER_WIDTH'(28'h7ff_ffff),
    parameter logic [PRESCALE_WIDTH-1:0] DEFAULT_PRESCALE = '0
) (
    input  logic           clk,
    input  logic           reset,
    watchdog_win_if.slave  bus,
    output logic           timeout
);

    logic                      w_wr;
    logic                      w_idle;
    logic                      w_running;
    logic                      w_expired;
    logic                      w_early;
    logic [TIMER_WIDTH-1:0]    w_curr_timer;
    logic                      w_unused_wdata;

    logic                      r_start;
    logic                      r_stop;
    logic                      r_kick;
    logic [TIMER_WIDTH-1:0]    r_timer_init;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
`ifdef WATCHDOG_WIN_WINDOW_EN
    logic [TIMER_WIDTH-1:0]    r_window;
`endif

    assign w_wr           = bus.cs && bus.we;
    assign w_idle         = !w_running && !w_expired;
    assign w_unused_wdata = ^bus.write_data;

    // CTRL bits are single-cycle pulses; the core sees them one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_kick  <= 1'b0;
        end else begin
            r_start <= w_wr && (bus.address == ADDR_CTRL) && bus.write_data[CTRL_START];
            r_stop  <= w_wr && (bus.address == ADDR_CTRL) && bus.write_data[CTRL_STOP];
            r_kick  <= w_wr && (bus.address == ADDR_CTRL) && bus.write_data[CTRL_KICK];
        end
    end

    // Configuration is frozen once the core leaves IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer_init <= DEFAULT_TIMEOUT;
            r_prescale   <= DEFAULT_PRESCALE;
`ifdef WATCHDOG_WIN_WINDOW_EN
            r_window     <= '1;
`endif
        end else if (w_wr && w_idle) begin
            case (bus.address)
                ADDR_TIMER_INIT: r_timer_init <= bus.write_data[TIMER_WIDTH-1:0];
                ADDR_PRESCALE:   r_prescale   <= bus.write_data[PRESCALE_WIDTH-1:0];
`ifdef WATCHDOG_WIN_WINDOW_EN
                ADDR_WINDOW:     r_window     <= bus.write_data[TIMER_WIDTH-1:0];
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.read_data = '0;
        if (bus.cs) begin
            case (bus.address)
                ADDR_STATUS:     bus.read_data = {29'd0, w_early, w_expired, w_running};
                ADDR_TIMER_INIT: bus.read_data = 32'(r_timer_init);
`ifdef WATCHDOG_WIN_WINDOW_EN
                ADDR_WINDOW:     bus.read_data = 32'(r_window);
`endif
                ADDR_PRESCALE:   bus.read_data = 32'(r_prescale);
                ADDR_CURR_TIMER: bus.read_data = 32'(w_curr_timer);
                default: ;
            endcase
        end
    end

    assign bus.ready = bus.cs;
    assign timeout   = w_expired;

    watchdog_win_core #(
        .TIMER_WIDTH    (TIMER_WIDTH),
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_core (
        .clk          (clk),
        .reset        (reset),
        .i_start      (r_start),
        .i_stop       (r_stop),
        .i_kick       (r_kick),
        .i_timer_init (r_timer_init),
`ifdef WATCHDOG_WIN_WINDOW_EN
        .i_window     (r_window),
`endif
        .i_prescale   (r_prescale),
        .o_running    (w_running),
        .o_expired    (w_expired),
        .o_early      (w_early),
        .o_curr_timer (w_curr_timer)
    );

endmodule

// File: tb/tb_watchdog_win.sv
// Directed bench for watchdog_win; expectations follow WATCHDOG_WIN_WINDOW_EN.
module tb_watchdog_win;
    import watchdog_win_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        timeout;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] rd;
    int          cyc;
    bit          found;

`ifdef WATCHDOG_WIN_WINDOW_EN
    localparam logic [31:0] WIN_RST = 32'h0fff_ffff;
`else
    localparam logic [31:0] WIN_RST = 32'h0000_0000;
`endif

    watchdog_win_if bus();

    watchdog_win dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        bus.cs = 1'b1; bus.we = 1'b1; bus.address = a; bus.write_data = d;
        @(posedge clk);
        #1;
        bus.cs = 1'b0; bus.we = 1'b0; bus.write_data = '0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        bus.cs = 1'b1; bus.we = 1'b0; bus.address = a;
        #1;
        d = bus.read_data;
        bus.cs = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic wait_timeout(input int start_cyc, output int c);
        c = start_cyc;
        while (!timeout && c < 200) begin
            tick(1);
            c++;
        end
    endtask

    task automatic poll_timer(input logic [31:0] target, output bit hit);
        logic [31:0] v;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            bus_read(ADDR_CURR_TIMER, v);
            if (v == target) hit = 1'b1;
            else tick(1);
        end
    endtask

    task automatic test_reset();
        bus.cs = 1'b0; bus.we = 1'b0; bus.address = ADDR_TIMER_INIT; bus.write_data = '0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        n_checks++; if (timeout !== 1'b0) $display("FAIL rst_timeout: got %b expected 0", timeout); else n_pass++;
        n_checks++; if (bus.ready !== 1'b0) $display("FAIL rst_ready_idle: got %b expected 0", bus.ready); else n_pass++;
        n_checks++; if (bus.read_data !== 32'd0) $display("FAIL rst_rdata_idle: got %h expected 0", bus.read_data); else n_pass++;
        bus.cs = 1'b1; #1;
        n_checks++; if (bus.ready !== 1'b1) $display("FAIL ready_cs: got %b expected 1", bus.ready); else n_pass++;
        bus.cs = 1'b0;
        bus_read(ADDR_TIMER_INIT, rd);
        n_checks++; if (rd !== 32'h07ff_ffff) $display("FAIL rst_timer_init: got %h expected %h", rd, 32'h07ff_ffff); else n_pass++;
        bus_read(ADDR_WINDOW, rd);
        n_checks++; if (rd !== WIN_RST) $display("FAIL rst_window: got %h expected %h", rd, WIN_RST); else n_pass++;
        bus_read(ADDR_PRESCALE, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL rst_prescale: got %h expected 0", rd); else n_pass++;
        bus_read(ADDR_STATUS, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL rst_status: got %h expected 0", rd); else n_pass++;
        bus_read(ADDR_CURR_TIMER, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL rst_curr: got %h expected 0", rd); else n_pass++;
        bus_read(8'h20, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL unmapped: got %h expected 0", rd); else n_pass++;
        tick(1);
    endtask

    task automatic test_expiry();
        apply_reset();
        bus_write(ADDR_TIMER_INIT, 32'd5);
        bus_write(ADDR_PRESCALE, 32'd1);
        bus_write(ADDR_CTRL, 32'h1);
        bus_read(ADDR_STATUS, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL start_latency_n1: got %h expected 0", rd); else n_pass++;
        tick(1);
        bus_read(ADDR_STATUS, rd);
        n_checks++; if (rd !== 32'h1) $display("FAIL status_running: got %h expected 1", rd); else n_pass++;
        bus_read(ADDR_CURR_TIMER, rd);
        n_checks++; if (rd !== 32'd5) $display("FAIL curr_loaded: got %0d expected 5", rd); else n_pass++;
        wait_timeout(2, cyc);
        n_checks++; if (cyc !== 14) $display("FAIL latency_t5_p1: got %0d expected 14", cyc); else n_pass++;
        bus_read(ADDR_STATUS, rd);
        n_checks++; if (rd !== 32'h2) $display("FAIL status_expired: got %h expected 2", rd); else n_pass++;
        bus_read(ADDR_CURR_TIMER, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL curr_expired: got %0d expected 0", rd); else n_pass++;

        apply_reset();
        bus_write(ADDR_TIMER_INIT, 32'd0);
        bus_write(ADDR_CTRL, 32'h1);
        wait_timeout(1, cyc);
        n_checks++; if (cyc !== 3) $display("FAIL latency_t0_p0: got %0d expected 3", cyc); else n_pass++;

        apply_reset();
        bus_write(ADDR_TIMER_INIT, 32'd1);
        bus_write(ADDR_PRESCALE, 32'd2);
        bus_write(ADDR_CTRL, 32'h1);
        wait_timeout(1, cyc);
        n_checks++; if (cyc !== 8) $display("FAIL latency_t1_p2: got %0d expected 8", cyc); else n_pass++;
    endtask

    task automatic test_write_lock();
        apply_reset();
        bus_write(ADDR_TIMER_INIT, 32'd100);
        bus_write(ADDR_CTRL, 32'h1);
        tick(1);
        bus_write(ADDR_TIMER_INIT, 32'd3);
        bus_read(ADDR_TIMER_INIT, rd);
        n_checks++; if (rd !== 32'd100) $display("FAIL init_locked: got %0d expected 100", rd); else n_pass++;
        bus_write(ADDR_PRESCALE, 32'd4);
        bus_read(ADDR_PRESCALE, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL prescale_locked: got %0d expected 0", rd); else n_pass++;
        bus_write(ADDR_CTRL, 32'h2);
        tick(1);
        bus_read(ADDR_STATUS, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL stop_idle: got %h expected 0", rd); else n_pass++;
        bus_write(ADDR_TIMER_INIT, 32'd3);
        bus_read(ADDR_TIMER_INIT, rd);
        n_checks++; if (rd !== 32'd3) $display("FAIL init_unlocked: got %0d expected 3", rd); else n_pass++;
        bus_write(ADDR_CTRL, 32'h3);
        tick(2);
        bus_read(ADDR_STATUS, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL start_stop_same: got %h expected 0", rd); else n_pass++;
        bus_write(ADDR_CTRL, 32'h1);
        bus_write(ADDR_CTRL, 32'h6);
        tick(2);
        bus_read(ADDR_STATUS, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL stop_kick_same: got %h expected 0", rd); else n_pass++;
    endtask

    task automatic test_kick();
        apply_reset();
        bus_write(ADDR_TIMER_INIT, 32'd100);
        bus_write(ADDR_WINDOW, 32'd20);
        bus_read(ADDR_WINDOW, rd);
`ifdef WATCHDOG_WIN_WINDOW_EN
        n_checks++; if (rd !== 32'd20) $display("FAIL window_rw: got %0d expected 20", rd); else n_pass++;
`else
        n_checks++; if (rd !== 32'd0) $display("FAIL window_absent: got %0d expected 0", rd); else n_pass++;
`endif
        bus_write(ADDR_CTRL, 32'h1);
        poll_timer(32'd11, found);
        n_checks++; if (found !== 1'b1) $display("FAIL poll_11: got %b expected 1", found); else n_pass++;
        bus_write(ADDR_CTRL, 32'h4);
        tick(1);
        bus_read(ADDR_CURR_TIMER, rd);
        n_checks++; if (rd !== 32'd100) $display("FAIL kick_reload: got %0d expected 100", rd); else n_pass++;
        bus_read(ADDR_STATUS, rd);
        n_checks++; if (rd !== 32'h1) $display("FAIL kick_status: got %h expected 1", rd); else n_pass++;
`ifdef WATCHDOG_WIN_WINDOW_EN
        poll_timer(32'd51, found);
        n_checks++; if (found !== 1'b1) $display("FAIL poll_51: got %b expected 1", found); else n_pass++;
        bus_write(ADDR_CTRL, 32'h4);
        tick(1);
        bus_read(ADDR_STATUS, rd);
        n_checks++; if (rd !== 32'h6) $display("FAIL early_status: got %h expected 6", rd); else n_pass++;
        n_checks++; if (timeout !== 1'b1) $display("FAIL early_timeout: got %b expected 1", timeout); else n_pass++;
`else
        poll_timer(32'd91, found);
        n_checks++; if (found !== 1'b1) $display("FAIL poll_91: got %b expected 1", found); else n_pass++;
        bus_write(ADDR_CTRL, 32'h4);
        tick(1);
        bus_read(ADDR_CURR_TIMER, rd);
        n_checks++; if (rd !== 32'd100) $display("FAIL nowin_reload: got %0d expected 100", rd); else n_pass++;
        bus_read(ADDR_STATUS, rd);
        n_checks++; if (rd !== 32'h1) $display("FAIL nowin_status: got %h expected 1", rd); else n_pass++;
`endif

        apply_reset();
        bus_write(ADDR_TIMER_INIT, 32'd5);
        bus_write(ADDR_CTRL, 32'h1);
        poll_timer(32'd1, found);
        n_checks++; if (found !== 1'b1) $display("FAIL poll_1: got %b expected 1", found); else n_pass++;
        bus_write(ADDR_CTRL, 32'h4);
        tick(1);
        bus_read(ADDR_CURR_TIMER, rd);
        n_checks++; if (rd !== 32'd5) $display("FAIL kick_at_zero_reload: got %0d expected 5", rd); else n_pass++;
        bus_read(ADDR_STATUS, rd);
        n_checks++; if (rd !== 32'h1) $display("FAIL kick_at_zero_status: got %h expected 1", rd); else n_pass++;
    endtask

    task automatic test_expired();
        apply_reset();
        bus_write(ADDR_TIMER_INIT, 32'd2);
        bus_write(ADDR_CTRL, 32'h1);
        wait_timeout(1, cyc);
        n_checks++; if (cyc !== 5) $display("FAIL latency_t2_p0: got %0d expected 5", cyc); else n_pass++;
        bus_write(ADDR_CTRL, 32'h1);
        tick(2);
        bus_read(ADDR_STATUS, rd);
        n_checks++; if (rd !== 32'h2) $display("FAIL exp_start_ignored: got %h expected 2", rd); else n_pass++;
        bus_write(ADDR_CTRL, 32'h2);
        tick(2);
        bus_read(ADDR_STATUS, rd);
        n_checks++; if (rd !== 32'h2) $display("FAIL exp_stop_ignored: got %h expected 2", rd); else n_pass++;
        bus_write(ADDR_CTRL, 32'h4);
        tick(2);
        bus_read(ADDR_STATUS, rd);
        n_checks++; if (rd !== 32'h2) $display("FAIL exp_kick_ignored: got %h expected 2", rd); else n_pass++;
        bus_read(ADDR_CURR_TIMER, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL exp_curr: got %0d expected 0", rd); else n_pass++;
        bus_write(ADDR_TIMER_INIT, 32'd9);
        bus_read(ADDR_TIMER_INIT, rd);
        n_checks++; if (rd !== 32'd2) $display("FAIL exp_init_locked: got %0d expected 2", rd); else n_pass++;
        apply_reset();
        bus_read(ADDR_STATUS, rd);
        n_checks++; if (rd !== 32'd0) $display("FAIL post_rst_status: got %h expected 0", rd); else n_pass++;
        n_checks++; if (timeout !== 1'b0) $display("FAIL post_rst_timeout: got %b expected 0", timeout); else n_pass++;
        bus_read(ADDR_TIMER_INIT, rd);
        n_checks++; if (rd !== 32'h07ff_ffff) $display("FAIL post_rst_init: got %h expected %h", rd, 32'h07ff_ffff); else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_expiry();
        test_write_lock();
        test_kick();
        test_expired();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
